fetch_control: RTL and testbench
================================

FETCH_CONTROL -- requirements
Module: fetch_control

Interface
REQ-001 Parameter: ADDR_W, 10, PC/jump address width in bits.
REQ-002 Port: clock  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: load_use_hazard  input  1  ID-stage load-use hazard; requests a one-cycle fetch stall.
REQ-005 Port: jump_taken  input  1  jump/branch resolved taken in ID; jump_target valid.
REQ-006 Port: jump_target  input  ADDR_W  resolved target address.
REQ-007 Port: halt_instr  input  1  halt opcode decoded in ID.
REQ-008 Port: dbg_mode  input  1  1 = single-step mode.
REQ-009 Port: dbg_step  input  1  one-cycle pulse; advances the pipeline front end by one cycle in step mode.
REQ-010 Port: dbg_resume  input  1  exit HALT.
REQ-011 Port: PC_write  output  1  PC register load enable.
REQ-012 Port: PC_sel  output  1  PC mux select; 0 = PC+1, 1 = jump_address.
REQ-013 Port: jump_address  output  ADDR_W  jump_target passed through.
REQ-014 Port: IFID_write  output  1  IF/ID register load enable.
REQ-015 Port: IFID_flush  output  1  IF/ID register clear (bubble insert).
REQ-016 Port: halted  output  1  1 while in HALT.
REQ-017 Port: state  output  2  current state encoding.
REQ-018 Port: fetch_count  output  32  cycles with PC_write=1 (see Configuration).
REQ-019 Port: stall_count  output  32  load-use stall cycles (see Configuration).

Function
REQ-020 FSM states SHALL be RUN=2'b00, STEP_WAIT=2'b01, HALT=2'b10; 2'b11 SHALL transition to RUN.
REQ-021 Control outputs SHALL be combinational from state and inputs; state, counters registered.
REQ-022 An "advance cycle" SHALL be any RUN cycle, or a STEP_WAIT cycle with dbg_step=1.
REQ-023 Advance-cycle priority SHALL be halt_instr > jump_taken > load_use_hazard > normal.
REQ-024 Advance, halt_instr=1: PC_write=0, IFID_write=0, IFID_flush=1; next state HALT.
REQ-025 Advance, jump_taken=1: PC_write=1, PC_sel=1, IFID_write=1, IFID_flush=1; load_use_hazard ignored.
REQ-026 Advance, load_use_hazard=1: PC_write=0, IFID_write=0, IFID_flush=0 (one-cycle freeze).
REQ-027 Advance, normal: PC_write=1, PC_sel=0, IFID_write=1, IFID_flush=0.
REQ-028 Non-halt advance: next state SHALL be STEP_WAIT if dbg_mode=1, else RUN.
REQ-029 STEP_WAIT with dbg_step=0: PC_write=0, IFID_write=0, IFID_flush=0; all ID inputs ignored; next = RUN if dbg_mode=0, else STEP_WAIT.
REQ-030 HALT: PC_write=0, IFID_write=0, IFID_flush=0, halted=1; dbg_resume=1 -> RUN next cycle; halt_instr, jump_taken, dbg_step ignored.
REQ-031 PC_sel SHALL be 0 in every cycle where REQ-025 does not apply; jump_address SHALL equal jump_target always.

Reset
REQ-032 reset=1 at a clock edge SHALL force state RUN and clear both counters, overriding all other inputs, from any state (incl. mid-HALT or STEP_WAIT).
REQ-033 During reset cycle outputs SHALL be PC_write=0, IFID_write=0, IFID_flush=1, PC_sel=0, halted=0.

Configuration
REQ-034 Macro FETCH_PERF_COUNT_EN defined: fetch_count increments each cycle PC_write=1, stall_count each cycle REQ-026 applies; both 32-bit, wrap 0xFFFFFFFF -> 0.
REQ-035 Macro undefined: counter registers SHALL not be built; fetch_count and stall_count tied to 0; FSM behaviour unchanged.

Verification
REQ-036 Reset, then 4 idle cycles -> PC_write=1, PC_sel=0, IFID_write=1 each cycle; fetch_count=4 (macro on).
REQ-037 RUN, load_use_hazard=1 and jump_taken=1, jump_target=10'h2A -> PC_write=1, PC_sel=1, jump_address=10'h2A, IFID_flush=1; stall_count unchanged.
REQ-038 RUN, halt_instr=1 -> IFID_flush=1, next cycle halted=1, PC_write=0 held 5 cycles; dbg_resume pulse -> RUN, PC_write=1 next cycle.
REQ-039 dbg_mode=1, three dbg_step pulses spaced 4 cycles -> exactly 3 cycles with PC_write=1 after the entry advance; dbg_mode=0 -> RUN next cycle.
REQ-040 reset asserted while in HALT -> next cycle state=2'b00, halted=0, counters 0; macro off -> counters read 0 throughout.

Source files
------------

// File: rtl/fetch_control.sv
// fetch_control: IF-stage front-end controller covering stalls, jumps, halt and debug single-step.
// Optional build macro FETCH_PERF_COUNT_EN adds fetch/stall performance counters.
// Without it, fetch_count and stall_count are tied to zero.
module fetch_control #(
   parameter int unsigned ADDR_W = 10
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              load_use_hazard,
   input  logic              jump_taken,
   input  logic [ADDR_W-1:0] jump_target,
   input  logic              halt_instr,
   input  logic              dbg_mode,
   input  logic              dbg_step,
   input  logic              dbg_resume,
   output logic              PC_write,
   output logic              PC_sel,
   output logic [ADDR_W-1:0] jump_address,
   output logic              IFID_write,
   output logic              IFID_flush,
   output logic              halted,
   output logic [1:0]        state,
   output logic [31:0]       fetch_count,
   output logic [31:0]       stall_count
);

   localparam int unsigned CNT_W = 32;

   typedef enum logic [1:0] {
      RUN       = 2'b00,
      STEP_WAIT = 2'b01,
      HALT      = 2'b10
   } state_e;

   state_e state_q, state_d;
   logic   advance_c;

   // A cycle advances the front end in RUN, or in STEP_WAIT when a step pulse arrives
   assign advance_c = (state_q == RUN) || ((state_q == STEP_WAIT) && dbg_step);

   assign jump_address = jump_target;
   assign state        = state_q;

   // Next-state and combinational pipeline control
   always_comb begin
      state_d    = state_q;
      PC_write   = 1'b0;
      PC_sel     = 1'b0;
      IFID_write = 1'b0;
      IFID_flush = 1'b0;
      halted     = 1'b0;
      if (reset) begin
         IFID_flush = 1'b1;
         state_d    = RUN;
      end else begin
         case (state_q)
            RUN, STEP_WAIT: begin
               if (advance_c) begin
                  if (halt_instr) begin
                     IFID_flush = 1'b1;
                     state_d    = HALT;
                  end else begin
                     if (jump_taken) begin
                        PC_write   = 1'b1;
                        PC_sel     = 1'b1;
                        IFID_write = 1'b1;
                        IFID_flush = 1'b1;
                     end else if (!load_use_hazard) begin
                        PC_write   = 1'b1;
                        IFID_write = 1'b1;
                     end
                     state_d = dbg_mode ? STEP_WAIT : RUN;
                  end
               end else begin
                  // Waiting for a step: front end frozen, ID requests ignored
                  state_d = dbg_mode ? STEP_WAIT : RUN;
               end
            end
            HALT: begin
               halted = 1'b1;
               if (dbg_resume) state_d = RUN;
            end
            default: state_d = RUN;
         endcase
      end
   end

   // State register
   always_ff @(posedge clock) begin
      if (reset) state_q <= RUN;
      else       state_q <= state_d;
   end

`ifdef FETCH_PERF_COUNT_EN
   logic [CNT_W-1:0] fetch_count_q, fetch_count_d;
   logic [CNT_W-1:0] stall_count_q, stall_count_d;
   logic             stall_c;

   // Load-use freeze is the advance case with no halt or jump overriding it
   assign stall_c = advance_c && !halt_instr && !jump_taken && load_use_hazard && !reset;

   // Counter increments; natural wrap at the top of the range
   always_comb begin
      fetch_count_d = fetch_count_q + CNT_W'(PC_write);
      stall_count_d = stall_count_q + CNT_W'(stall_c);
   end

   // Counter registers
   always_ff @(posedge clock) begin
      if (reset) begin
         fetch_count_q <= '0;
         stall_count_q <= '0;
      end else begin
         fetch_count_q <= fetch_count_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign fetch_count = fetch_count_q;
   assign stall_count = stall_count_q;
`else
   assign fetch_count = '0;
   assign stall_count = '0;
`endif

endmodule

// File: tb/tb_fetch_control.sv
// Directed bench for fetch_control; expectations follow FETCH_PERF_COUNT_EN when defined.
module tb_fetch_control;

   localparam int unsigned ADDR_W = 10;
`ifdef FETCH_PERF_COUNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic              clock = 1'b0;
   logic              reset;
   logic              load_use_hazard, jump_taken, halt_instr;
   logic              dbg_mode, dbg_step, dbg_resume;
   logic [ADDR_W-1:0] jump_target;
   logic              PC_write, PC_sel, IFID_write, IFID_flush, halted;
   logic [ADDR_W-1:0] jump_address;
   logic [1:0]        state;
   logic [31:0]       fetch_count, stall_count;

   int n_vec = 0;
   int n_err = 0;
   int exp_fc = 0;
   int exp_sc = 0;
   int step_writes;

   fetch_control #(.ADDR_W(ADDR_W)) dut (
      .clock(clock), .reset(reset),
      .load_use_hazard(load_use_hazard), .jump_taken(jump_taken),
      .jump_target(jump_target), .halt_instr(halt_instr),
      .dbg_mode(dbg_mode), .dbg_step(dbg_step), .dbg_resume(dbg_resume),
      .PC_write(PC_write), .PC_sel(PC_sel), .jump_address(jump_address),
      .IFID_write(IFID_write), .IFID_flush(IFID_flush), .halted(halted),
      .state(state), .fetch_count(fetch_count), .stall_count(stall_count)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Check the five control outputs in one call
   task automatic chk_ctl(input string tag, input logic pw, input logic ps,
                          input logic iw, input logic fl, input logic hl);
      chk({tag, ".PC_write"},   32'(PC_write),   32'(pw));
      chk({tag, ".PC_sel"},     32'(PC_sel),     32'(ps));
      chk({tag, ".IFID_write"}, 32'(IFID_write), 32'(iw));
      chk({tag, ".IFID_flush"}, 32'(IFID_flush), 32'(fl));
      chk({tag, ".halted"},     32'(halted),     32'(hl));
   endtask

   task automatic chk_cnt(input string tag);
      chk({tag, ".fetch_count"}, fetch_count, PERF ? 32'(exp_fc) : 32'd0);
      chk({tag, ".stall_count"}, stall_count, PERF ? 32'(exp_sc) : 32'd0);
   endtask

   // Advance one clock and settle just after the edge
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1'b1; load_use_hazard = 1'b0; jump_taken = 1'b0; halt_instr = 1'b0;
      dbg_mode = 1'b0; dbg_step = 1'b0; dbg_resume = 1'b0; jump_target = '0;

      // Reset cycle outputs and state
      tick();
      #1;
      chk_ctl("reset", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("reset.state", 32'(state), 32'd0);
      chk_cnt("reset");
      reset = 1'b0;

      // Four idle RUN cycles
      for (int i = 0; i < 4; i++) begin
         #1;
         chk_ctl("idle", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
         exp_fc++;
         tick();
      end
      chk_cnt("idle4");

      // Load-use freeze
      load_use_hazard = 1'b1;
      #1;
      chk_ctl("stall", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      exp_sc++;
      tick();
      chk_cnt("stall");

      // Jump beats load-use hazard
      jump_taken = 1'b1; jump_target = 10'h2A;
      #1;
      chk_ctl("jump", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("jump.jump_address", 32'(jump_address), 32'h2A);
      exp_fc++;
      tick();
      chk_cnt("jump");

      // Halt beats jump and load-use
      halt_instr = 1'b1;
      #1;
      chk_ctl("halt_in", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      load_use_hazard = 1'b0;
      chk("halt.state", 32'(state), 32'd2);
      for (int i = 0; i < 5; i++) begin
         dbg_step = i[0];
         #1;
         chk_ctl("halted", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
         tick();
      end
      halt_instr = 1'b0; jump_taken = 1'b0; dbg_step = 1'b0;
      chk("halt_hold.state", 32'(state), 32'd2);
      chk_cnt("halt_hold");

      // Resume from HALT
      dbg_resume = 1'b1;
      #1;
      chk_ctl("resume", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      dbg_resume = 1'b0;
      chk("resume.state", 32'(state), 32'd0);
      #1;
      chk_ctl("post_resume", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      exp_fc++;
      tick();

      // Enter single-step: this RUN cycle is the entry advance
      dbg_mode = 1'b1;
      #1;
      chk_ctl("step_entry", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      exp_fc++;
      tick();
      chk("step_entry.state", 32'(state), 32'd1);

      // Three step pulses spaced four cycles; ID requests ignored while waiting
      step_writes = 0;
      for (int p = 0; p < 3; p++) begin
         for (int i = 0; i < 3; i++) begin
            load_use_hazard = 1'b1; jump_taken = (i == 1);
            #1;
            chk_ctl("step_wait", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            step_writes += int'(PC_write);
            tick();
         end
         load_use_hazard = 1'b0; jump_taken = 1'b0;
         dbg_step = 1'b1;
         #1;
         chk_ctl("step_pulse", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
         step_writes += int'(PC_write);
         exp_fc++;
         tick();
         dbg_step = 1'b0;
         chk("step_pulse.state", 32'(state), 32'd1);
      end
      chk("step_writes", 32'(step_writes), 32'd3);
      chk_cnt("step");

      // Leave step mode without a pulse
      dbg_mode = 1'b0;
      #1;
      chk_ctl("step_exit", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      chk("step_exit.state", 32'(state), 32'd0);
      #1;
      chk_ctl("run_again", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      exp_fc++;
      tick();
      chk_cnt("run_again");

      // Reset from HALT
      halt_instr = 1'b1;
      tick();
      halt_instr = 1'b0;
      chk("pre_reset.state", 32'(state), 32'd2);
      reset = 1'b1;
      #1;
      chk_ctl("reset_halt", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      reset = 1'b0;
      exp_fc = 0; exp_sc = 0;
      chk("reset_halt.state", 32'(state), 32'd0);
      chk("reset_halt.halted", 32'(halted), 32'd0);
      chk_cnt("reset_halt");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
